// File: rtl/ariane_pkg.sv
// Shared frontend types: per-lane BHT prediction and the gshare resolution bundle.
package ariane_pkg;

    // Widest PC / history a gshare_upd_t can carry; narrower configurations zero-extend.
    localparam int GSHARE_PC_W   = 64;
    localparam int GSHARE_HIST_W = 16;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic                     valid;
        logic [GSHARE_PC_W-1:0]   pc;
        logic                     taken;
        logic                     mispredict;
        logic [GSHARE_HIST_W-1:0] hist;
    } gshare_upd_t;

endpackage

// File: rtl/gshare_table.sv
// Gshare counter array: registered row read, single-entry read-modify-write port, row-wide init write.
module gshare_table #(
    parameter int NR_ROWS         = 512,
    parameter int INSTR_PER_FETCH = 2,
    parameter int CTR_BITS        = 2,
    parameter int ROW_BITS        = $clog2(NR_ROWS),
    parameter int LANE_BITS       = $clog2(INSTR_PER_FETCH)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      rd_en_i,
    input  logic [ROW_BITS-1:0]                       rd_row_i,
    output logic [INSTR_PER_FETCH-1:0][CTR_BITS:0]    rd_data_o,
    input  logic                                      wr_en_i,
    input  logic [ROW_BITS-1:0]                       wr_row_i,
    input  logic [LANE_BITS-1:0]                      wr_lane_i,
    input  logic [CTR_BITS:0]                         wr_data_i,
    output logic [CTR_BITS:0]                         wr_old_o,
    input  logic                                      init_en_i,
    input  logic [ROW_BITS-1:0]                       init_row_i
);

    // Entry = {valid, ctr}; init value is invalid and weakly taken.
    localparam logic [CTR_BITS:0] INIT_ENTRY = (CTR_BITS+1)'(1) << (CTR_BITS-1);

    logic [INSTR_PER_FETCH-1:0][CTR_BITS:0] mem [NR_ROWS];

    assign wr_old_o = mem[wr_row_i][wr_lane_i];

    always_ff @(posedge clk_i) begin
        if (init_en_i) begin
            mem[init_row_i] <= {INSTR_PER_FETCH{INIT_ENTRY}};
        end else if (wr_en_i) begin
            mem[wr_row_i][wr_lane_i] <= wr_data_i;
        end
    end

    // Read samples the array before this edge's write lands, so a colliding lookup sees old data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_row_i];
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch predictor: INIT/READY sweep FSM, global history and counter update.
// Optional GSHARE_BP_SPEC_HIST_EN: speculative GHR shift with repair on mispredict.
module gshare_bp import ariane_pkg::*; #(
    parameter int VLEN            = 64,
    parameter int NR_ENTRIES      = 1024,
    parameter int INSTR_PER_FETCH = 2,
    parameter int HIST_BITS       = 9,
    parameter int CTR_BITS        = 2,
    parameter int OFFSET          = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_bp_i,
    input  logic                                   debug_mode_i,
    input  logic                                   pred_req_i,
    input  logic [VLEN-1:0]                        vpc_i,
    output logic                                   pred_valid_o,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]  bht_prediction_o,
    output logic [HIST_BITS-1:0]                   pred_hist_o,
    input  logic                                   spec_update_i,
    input  logic                                   spec_taken_i,
    input  logic                                   upd_valid_i,
    input  logic [VLEN-1:0]                        upd_pc_i,
    input  logic                                   upd_taken_i,
    input  logic                                   upd_mispredict_i,
    input  logic [HIST_BITS-1:0]                   upd_hist_i,
    output logic                                   upd_correct_o,
    output logic                                   busy_o
);

    localparam int LANE_BITS = $clog2(INSTR_PER_FETCH);
    localparam int NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int ROW_BITS  = $clog2(NR_ROWS);
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [0:0]                             state_q;
    logic [ROW_BITS-1:0]                    init_row_q;
    logic [HIST_BITS-1:0]                   ghr_q;
    gshare_upd_t                            upd;
    logic                                   ready, upd_acc, lookup_acc;
    logic [ROW_BITS-1:0]                    rd_row, upd_row;
    logic [LANE_BITS-1:0]                   upd_lane;
    logic [CTR_BITS:0]                      wr_old;
    logic [CTR_BITS-1:0]                    old_ctr, new_ctr;
    logic [INSTR_PER_FETCH-1:0][CTR_BITS:0] rd_data;
    logic                                   unused_ok;

    always_comb begin
        upd            = '0;
        upd.valid      = upd_valid_i;
        upd.pc         = GSHARE_PC_W'(upd_pc_i);
        upd.taken      = upd_taken_i;
        upd.mispredict = upd_mispredict_i;
        upd.hist       = GSHARE_HIST_W'(upd_hist_i);
    end

    assign ready      = (state_q == READY);
    assign upd_acc    = upd.valid && !debug_mode_i && ready;
    assign lookup_acc = pred_req_i && ready;
    assign busy_o     = (state_q == INIT);

    // Lookups hash with the live GHR; updates hash with the history snapshot taken at predict time.
    assign rd_row   = vpc_i[OFFSET+LANE_BITS +: ROW_BITS] ^ ROW_BITS'(ghr_q);
    assign upd_row  = upd.pc[OFFSET+LANE_BITS +: ROW_BITS] ^ ROW_BITS'(upd.hist[HIST_BITS-1:0]);
    assign upd_lane = upd.pc[OFFSET +: LANE_BITS];
    assign old_ctr  = wr_old[CTR_BITS-1:0];

    always_comb begin
        new_ctr = old_ctr;
        if (upd.taken) begin
            if (old_ctr != CTR_MAX) new_ctr = old_ctr + 1'b1;
        end else if (old_ctr != '0) begin
            new_ctr = old_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_bp_i) begin
            state_q    <= INIT;
            init_row_q <= '0;
        end else if (state_q == INIT) begin
            if (init_row_q == ROW_BITS'(NR_ROWS-1)) state_q <= READY;
            init_row_q <= init_row_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_bp_i || !ready) begin
            ghr_q <= '0;
        end else begin
`ifdef GSHARE_BP_SPEC_HIST_EN
            if (upd_acc && upd.mispredict) begin
                ghr_q <= {upd.hist[HIST_BITS-2:0], upd.taken};
            end else if (spec_update_i) begin
                ghr_q <= {ghr_q[HIST_BITS-2:0], spec_taken_i};
            end
`else
            if (upd_acc) ghr_q <= {ghr_q[HIST_BITS-2:0], upd.taken};
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pred_valid_o  <= 1'b0;
            pred_hist_o   <= '0;
            upd_correct_o <= 1'b0;
        end else begin
            pred_valid_o  <= lookup_acc;
            if (lookup_acc) pred_hist_o <= ghr_q;
            upd_correct_o <= upd_acc && (old_ctr[CTR_BITS-1] == upd.taken);
        end
    end

    gshare_table #(
        .NR_ROWS         (NR_ROWS),
        .INSTR_PER_FETCH (INSTR_PER_FETCH),
        .CTR_BITS        (CTR_BITS)
    ) u_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_en_i    (lookup_acc),
        .rd_row_i   (rd_row),
        .rd_data_o  (rd_data),
        .wr_en_i    (upd_acc),
        .wr_row_i   (upd_row),
        .wr_lane_i  (upd_lane),
        .wr_data_i  ({1'b1, new_ctr}),
        .wr_old_o   (wr_old),
        .init_en_i  (busy_o),
        .init_row_i (init_row_q)
    );

    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_lane
        assign bht_prediction_o[i].valid = rd_data[i][CTR_BITS];
        assign bht_prediction_o[i].taken = rd_data[i][CTR_BITS-1];
    end

    assign unused_ok = ^{vpc_i, upd, rd_data, spec_update_i, spec_taken_i};

endmodule
